logic_unit_sequencer: RTL and testbench

Self-test sequencer for the lab's two-input logic unit, whose outputs are A passthrough, A AND B, and NOT A. On a start pulse it drives the unit's A/B inputs through all four input combinations, holds each for a programmable settle time, then samples and checks the three outputs against expected values. It reports a per-sweep mismatch count and a pass flag. It sits between the board control inputs and the logic unit and owns the unit's A/B inputs whenever it is enabled.

---
 rtl/logic_unit_sequencer_if.sv | 35 +++
 rtl/logic_unit_sequencer.sv | 122 ++++++++++++
 tb/tb_logic_unit_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_sequencer_if.sv
// ---------------------------------------------------------------------------
// logic_unit_sequencer_if : control and logic-unit signals of the sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface logic_unit_sequencer_if;
  logic       start;
  logic       abort;
  logic       mode;
  logic       aout_in;
  logic       aandb_in;
  logic       nota_in;
  logic       a_out;
  logic       b_out;
  logic [1:0] vec_idx;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;

  // Sequencer side
  modport master (
    input  start, abort, mode, aout_in, aandb_in, nota_in,
    output a_out, b_out, vec_idx, busy, done, pass, err_count
  );

  // Board control / logic unit side
  modport slave (
    output start, abort, mode, aout_in, aandb_in, nota_in,
    input  a_out, b_out, vec_idx, busy, done, pass, err_count
  );
endinterface

`default_nettype wire

// File: rtl/logic_unit_sequencer.sv
// ---------------------------------------------------------------------------
// logic_unit_sequencer : sweeps a 2-input logic unit through all vectors
// and counts vectors whose A / A&B / ~A outputs are wrong.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module logic_unit_sequencer #(
  parameter int unsigned DWELL = 4
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  logic_unit_sequencer_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] C_DWELL_LAST = 8'(DWELL - 1);

  state_t     r_state;
  logic [7:0] r_settle_cnt;
  logic [1:0] r_vec;
  logic [2:0] r_err;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic       w_mismatch;

  // Vector bits are {A, B}; the unit is checked against its ideal truth table.
  assign w_mismatch = (bus.aout_in  != r_vec[1]) ||
                      (bus.aandb_in != (r_vec[1] & r_vec[0])) ||
                      (bus.nota_in  != ~r_vec[1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_settle_cnt <= 8'd0;
      r_vec        <= 2'd0;
      r_err        <= 3'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else if (bus.abort) begin
      // Partial error count and previous pass result are deliberately kept.
      r_state      <= IDLE;
      r_settle_cnt <= 8'd0;
      r_vec        <= 2'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_vec <= 2'd0;
          if (bus.start) begin
            r_state      <= SETTLE;
            r_settle_cnt <= 8'd0;
            r_err        <= 3'd0;
            r_busy       <= 1'b1;
          end
        end

        SETTLE: begin
          if (r_settle_cnt == C_DWELL_LAST) begin
            r_state <= SAMPLE;
          end else begin
            r_settle_cnt <= r_settle_cnt + 8'd1;
          end
        end

        SAMPLE: begin
          if (w_mismatch && (r_err != 3'd4)) begin
            r_err <= r_err + 3'd1;
          end
          if (r_vec != 2'd3) begin
            r_vec        <= r_vec + 2'd1;
            r_settle_cnt <= 8'd0;
            r_state      <= SETTLE;
          end else begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end

        DONE: begin
          r_pass <= (r_err == 3'd0);
          r_vec  <= 2'd0;
          if (bus.mode) begin
            r_state      <= SETTLE;
            r_settle_cnt <= 8'd0;
            r_err        <= 3'd0;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_vec   <= 2'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a_out     = r_vec[1];
  assign bus.b_out     = r_vec[0];
  assign bus.vec_idx   = r_vec;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.err_count = r_err;

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_sequencer.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_sequencer : two sequencer instances (DWELL 4 and 2) driven in
// lockstep and compared each cycle against a sweep-offset reference model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_logic_unit_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       mode;
  logic [1:0] fault;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  logic_unit_sequencer_if if4 ();
  logic_unit_sequencer_if if2 ();

  // Unit under test: 0 healthy, 1 AandB stuck at 1, 2 notA inverted, 3 Aout stuck at 0
  function automatic logic [2:0] unit(input logic [1:0] f, input logic a, input logic b);
    logic [2:0] r;
    r = {a, a & b, ~a};
    case (f)
      2'd1: r[1] = 1'b1;
      2'd2: r[0] = ~r[0];
      2'd3: r[2] = 1'b0;
      default: ;
    endcase
    return r;
  endfunction

  assign if4.start = start;
  assign if4.abort = abort;
  assign if4.mode  = mode;
  assign {if4.aout_in, if4.aandb_in, if4.nota_in} = unit(fault, if4.a_out, if4.b_out);
  assign if2.start = start;
  assign if2.abort = abort;
  assign if2.mode  = mode;
  assign {if2.aout_in, if2.aandb_in, if2.nota_in} = unit(fault, if2.a_out, if2.b_out);

  logic_unit_sequencer #(.DWELL(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  logic_unit_sequencer #(.DWELL(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  // Reference model: n = cycle offset inside the current sweep (0 = idle).
  int         dw [2] = '{4, 2};
  int         n  [2] = '{0, 0};
  logic [2:0] m_err [2] = '{3'd0, 3'd0};
  logic       m_pass[2] = '{1'b0, 1'b0};

  function automatic bit vec_fails(input logic [1:0] f, input int k);
    logic a, b;
    a = (k >= 2);
    b = ((k % 2) == 1);
    return unit(f, a, b) != {a, a & b, ~a};
  endfunction

  task automatic model_edge();
    int d, s;
    for (int i = 0; i < 2; i++) begin
      d = dw[i];
      s = 4 * (d + 1);
      if (!rst_n) begin
        n[i] = 0; m_err[i] = 3'd0; m_pass[i] = 1'b0;
      end else if (abort) begin
        n[i] = 0;
      end else if (n[i] == 0) begin
        if (start) begin n[i] = 1; m_err[i] = 3'd0; end
      end else if (n[i] == s + 1) begin
        m_pass[i] = (m_err[i] == 3'd0);
        if (mode) begin n[i] = 1; m_err[i] = 3'd0; end
        else n[i] = 0;
      end else begin
        if ((n[i] % (d + 1)) == 0 && vec_fails(fault, n[i] / (d + 1) - 1) && m_err[i] < 3'd4)
          m_err[i] = m_err[i] + 3'd1;
        n[i] = n[i] + 1;
      end
    end
  endtask

  function automatic logic [1:0] exp_vec(input int i);
    int s;
    s = 4 * (dw[i] + 1);
    if (n[i] >= 1 && n[i] <= s) return 2'((n[i] - 1) / (dw[i] + 1));
    if (n[i] == s + 1) return 2'd3;
    return 2'd0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic chk_inst(input int i, input logic busy, input logic done, input logic pass,
                          input logic [2:0] err, input logic [1:0] vec, input logic a, input logic b);
    logic [1:0] ev;
    ev = exp_vec(i);
    chk($sformatf("d%0d busy", dw[i]), int'(busy), int'(n[i] != 0));
    chk($sformatf("d%0d done", dw[i]), int'(done), int'(n[i] == 4 * (dw[i] + 1) + 1));
    chk($sformatf("d%0d pass", dw[i]), int'(pass), int'(m_pass[i]));
    chk($sformatf("d%0d err_count", dw[i]), int'(err), int'(m_err[i]));
    chk($sformatf("d%0d vec_idx", dw[i]), int'(vec), int'(ev));
    chk($sformatf("d%0d a_out", dw[i]), int'(a), int'(ev[1]));
    chk($sformatf("d%0d b_out", dw[i]), int'(b), int'(ev[0]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk_inst(0, if4.busy, if4.done, if4.pass, if4.err_count, if4.vec_idx, if4.a_out, if4.b_out);
    chk_inst(1, if2.busy, if2.done, if2.pass, if2.err_count, if2.vec_idx, if2.a_out, if2.b_out);
  endtask

  task automatic go_idle();
    start = 1'b0; abort = 1'b1; step(); abort = 1'b0;
  endtask

  typedef struct {
    logic [1:0] fault;
    int         exp_err;
    logic       exp_pass;
  } sweep_t;

  sweep_t tbl [5];

  initial begin
    int d4, d2, nd4, nd2;
    int dq [$];

    tbl[0] = '{2'd0, 0, 1'b1};
    tbl[1] = '{2'd1, 3, 1'b0};
    tbl[2] = '{2'd2, 4, 1'b0};
    tbl[3] = '{2'd3, 2, 1'b0};
    tbl[4] = '{2'd0, 0, 1'b1};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; fault = 2'd0;
    step(); step();
    chk("reset busy", int'(if4.busy), 0);
    chk("reset err_count", int'(if4.err_count), 0);
    chk("reset pass", int'(if4.pass), 0);
    rst_n = 1'b1;
    step();

    // Single sweeps over the fault table
    foreach (tbl[t]) begin
      fault = tbl[t].fault; mode = 1'b0;
      d4 = -1; d2 = -1; nd4 = 0; nd2 = 0;
      start = 1'b1; step(); start = 1'b0;
      for (int c = 1; c <= 30; c++) begin
        if (if4.done) begin nd4++; if (d4 < 0) d4 = c; end
        if (if2.done) begin nd2++; if (d2 < 0) d2 = c; end
        if (c == 22) chk("busy low after done", int'(if4.busy), 0);
        step();
      end
      chk($sformatf("sweep%0d done cycle d4", t), d4, 21);
      chk($sformatf("sweep%0d done cycle d2", t), d2, 13);
      chk($sformatf("sweep%0d done count", t), nd4 + nd2, 2);
      chk($sformatf("sweep%0d err d4", t), int'(if4.err_count), tbl[t].exp_err);
      chk($sformatf("sweep%0d err d2", t), int'(if2.err_count), tbl[t].exp_err);
      chk($sformatf("sweep%0d pass d4", t), int'(if4.pass), int'(tbl[t].exp_pass));
      chk($sformatf("sweep%0d pass d2", t), int'(if2.pass), int'(tbl[t].exp_pass));
    end

    // Abort in SAMPLE of vector 2 (cycle 15 for DWELL 4) after a passing sweep
    fault = 2'd1;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c < 15; c++) step();
    abort = 1'b1; step(); abort = 1'b0;
    chk("abort busy", int'(if4.busy), 0);
    chk("abort a_out", int'(if4.a_out), 0);
    chk("abort done", int'(if4.done), 0);
    chk("abort pass held", int'(if4.pass), 1);
    chk("abort err partial", int'(if4.err_count), 2);

    // Start held high: exactly one done in the first sweep
    fault = 2'd0; nd4 = 0;
    start = 1'b1;
    for (int c = 0; c < 21; c++) begin step(); if (if4.done) nd4++; end
    chk("held start done count", nd4, 1);
    step(); step();
    go_idle();

    // Continuous mode with Aout stuck at 0
    fault = 2'd3; mode = 1'b1; dq.delete();
    start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 63; c++) begin
      if (if4.done) dq.push_back(c);
      if (if4.busy !== 1'b1) chk("continuous busy", int'(if4.busy), 1);
      if (c == 21) chk("continuous err at done", int'(if4.err_count), 2);
      if (c == 22) chk("continuous err cleared", int'(if4.err_count), 0);
      step();
    end
    chk("continuous done count", dq.size(), 3);
    if (dq.size() == 3) begin
      chk("continuous done 1", dq[0], 21);
      chk("continuous done 2", dq[1], 42);
      chk("continuous done 3", dq[2], 63);
    end
    mode = 1'b0;
    go_idle();

    // Reset mid-sweep
    fault = 2'd2;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 12; c++) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("mid reset busy", int'(if4.busy), 0);
    chk("mid reset vec", int'(if4.vec_idx), 0);
    chk("mid reset err", int'(if4.err_count), 0);
    chk("mid reset pass", int'(if4.pass), 0);

    // Start and abort together in IDLE
    start = 1'b1; abort = 1'b1; step();
    chk("start+abort busy", int'(if4.busy), 0);
    start = 1'b0; abort = 1'b0; step();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      abort = ($urandom_range(0, 79) == 0);
      start = ($urandom_range(0, 5) == 0);
      mode  = ($urandom_range(0, 2) == 0);
      if (n[0] == 0 && n[1] == 0) fault = 2'($urandom_range(0, 3));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
